// File: rtl/rv_pkg.sv
// Shared pipeline types and constants for the IF/ID boundary, also used by the decode stage and hazard unit.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } if_id_entry_t;
endpackage

// File: rtl/if_id_queue_mem.sv
// Storage for the IF/ID queue: DEPTH registers, synchronous write, asynchronous read.
module if_id_queue_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == AW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rd_data = entries[rd_addr];
endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue with flush on taken branch.
// Optional zero-latency pass-through when empty: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
    import rv_pkg::*;
#(
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_pc4,
    input  logic [XLEN-1:0]        in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc4,
    output logic [XLEN-1:0]        out_instr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          empty, full, bypass, push, pop;
    if_id_entry_t  wr_entry, rd_entry;

    assign wr_entry = '{pc: in_pc, pc4: in_pc4, instr: in_instr};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(if_id_entry_t))
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_entry)
    );

    always_comb begin
        empty    = (count_reg == '0);
        full     = (count_reg == CW'(DEPTH));
`ifdef IF_ID_QUEUE_BYPASS_EN
        bypass   = empty & in_valid & ~flush;
`else
        bypass   = 1'b0;
`endif
        // in_ready looks at registered occupancy only, so full+pop still refuses the push
        in_ready  = ~full;
        out_valid = ~flush & (~empty | bypass);
        push      = in_valid & ~full & ~flush & ~(bypass & out_ready);
        pop       = out_ready & ~empty & ~flush;

        out_pc    = '0;
        out_pc4   = '0;
        out_instr = NOP;
        if (bypass) begin
            out_pc    = in_pc;
            out_pc4   = in_pc4;
            out_instr = in_instr;
        end else if (!empty) begin
            out_pc    = rd_entry.pc;
            out_pc4   = rd_entry.pc4;
            out_instr = rd_entry.instr;
        end

        wr_ptr_next = wr_ptr_reg + AW'(push);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        count_next  = count_reg + CW'(push) - CW'(pop);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_reg <= CW'(DEPTH));
        end
    end
endmodule
